// File: rtl/encode_smem.sv
// SMEM instruction encoder: takes one structured instruction per handshake and
// emits its two 32-bit dwords (dword0 then dword1) to the fetch/decode path.

package encode_smem_pkg;
  typedef struct packed {
    logic [5:0]  sbase;
    logic [6:0]  sdata;
    logic        dlc;
    logic        glc;
    logic [7:0]  op;
    logic [20:0] offset;
    logic [6:0]  soffset;
  } smem_inst_t;
endpackage

module encode_smem
  import encode_smem_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [5:0]  SMEM_ENC = 6'b111101
) (
  input  logic             clk,
  input  logic             reset,
  input  smem_inst_t       in_inst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_dword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DW0  = 2'd1,
    DW1  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  smem_inst_t hold;
  logic       in_hs;
  logic       out_hs;

  // State, holding register and emitted-instruction counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      hold       <= '0;
      inst_count <= '0;
    end else begin
      state <= state_next;
      if (in_hs) begin
        hold <= in_inst;
      end
      if (out_hs && (state == DW1)) begin
        inst_count <= inst_count + CNT_W'(1);
      end
    end
  end

  // Next state and state-decoded outputs; the dword is built only from the held copy
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    out_dword  = 32'h0;
    in_hs      = 1'b0;
    out_hs     = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        in_hs    = in_valid;
        if (in_hs) begin
          state_next = DW0;
        end
      end
      DW0: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_hs    = out_ready;
        out_dword = {SMEM_ENC, hold.op, 1'b0, hold.glc, 1'b0, hold.dlc, 1'b0,
                     hold.sdata, hold.sbase};
        if (out_hs) begin
          state_next = DW1;
        end
      end
      DW1: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        busy      = 1'b1;
        in_ready  = out_ready;
        out_hs    = out_ready;
        in_hs     = in_valid && out_ready;
        out_dword = {hold.soffset, 4'b0000, hold.offset};
        if (out_hs) begin
          state_next = in_hs ? DW0 : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_encode_smem.sv
// Directed bench for encode_smem: encodings, latency, stall, back-to-back, reset, counter wrap.

module tb_encode_smem;

  logic        clk;
  logic        reset;
  logic [50:0] in_inst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_dword;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [15:0] inst_count;

  logic        in_ready2;
  logic [31:0] out_dword2;
  logic        out_valid2;
  logic        out_last2;
  logic        busy2;
  logic [1:0]  inst_count2;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt = 16'd0;

  // Field order: sbase, sdata, dlc, glc, op, offset, soffset (sbase is MSB)
  logic [50:0] inst_a;
  logic [50:0] inst_ones;
  logic [50:0] inst_c;
  logic [50:0] inst_junk;

  encode_smem #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_inst(in_inst), .in_valid(in_valid),
    .in_ready(in_ready), .out_dword(out_dword), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .inst_count(inst_count)
  );

  encode_smem #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_inst(in_inst), .in_valid(in_valid),
    .in_ready(in_ready2), .out_dword(out_dword2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_last(out_last2), .busy(busy2),
    .inst_count(inst_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = '0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_dword !== 32'h0) begin bad++; $display("FAIL reset_out_dword got=%h want=00000000", out_dword); end
    total++; if (out_last !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_last_busy got=%b%b want=00", out_last, busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (inst_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", inst_count); end
    reset = 1'b1;
    exp_cnt = 16'd0;
    @(negedge clk);
  endtask

  task automatic test_single(input string name, input logic [50:0] inst,
                             input logic [31:0] dw0, input logic [31:0] dw1);
    in_inst = inst; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_dword !== dw0 || out_last !== 1'b0)
      begin bad++; $display("FAIL %s_dw0 got=%b/%h/%b want=1/%h/0", name, out_valid, out_dword, out_last, dw0); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL %s_dw0_in_ready got=%b want=0", name, in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_dword !== dw1 || out_last !== 1'b1)
      begin bad++; $display("FAIL %s_dw1 got=%b/%h/%b want=1/%h/1", name, out_valid, out_dword, out_last, dw1); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_dw1_in_ready got=%b want=1", name, in_ready); end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_dword !== 32'h0)
      begin bad++; $display("FAIL %s_idle got=%b/%b/%h want=0/0/00000000", name, busy, out_valid, out_dword); end
    total++; if (inst_count !== exp_cnt) begin bad++; $display("FAIL %s_count got=%0d want=%0d", name, inst_count, exp_cnt); end
  endtask

  task automatic test_backpressure();
    in_inst = inst_a; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    // Offer a different instruction during the stall; it must not be taken
    in_inst = inst_junk;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_dword !== 32'hF4090404 || out_last !== 1'b0 || in_ready !== 1'b0)
        begin bad++; $display("FAIL stall_%0d got=%b/%h/%b/%b want=1/F4090404/0/0", i, out_valid, out_dword, out_last, in_ready); end
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_dword !== 32'hFA000040 || out_last !== 1'b1)
      begin bad++; $display("FAIL stall_release got=%h/%b want=FA000040/1", out_dword, out_last); end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    total++; if (busy !== 1'b0 || inst_count !== exp_cnt)
      begin bad++; $display("FAIL stall_done got=%b/%0d want=0/%0d", busy, inst_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [50:0] insts [3];
    logic [31:0] exp_dw [6];
    insts[0] = inst_a; insts[1] = inst_ones; insts[2] = inst_c;
    exp_dw[0] = 32'hF4090404; exp_dw[1] = 32'hFA000040;
    exp_dw[2] = 32'hF7FD5FFF; exp_dw[3] = 32'hFE1FFFFF;
    exp_dw[4] = 32'hF5684000; exp_dw[5] = 32'h02012345;
    in_inst = insts[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_dword !== exp_dw[c] || out_last !== c[0])
        begin bad++; $display("FAIL b2b_%0d got=%b/%h/%b want=1/%h/%b", c, out_valid, out_dword, out_last, exp_dw[c], c[0]); end
      total++; if (in_ready !== c[0])
        begin bad++; $display("FAIL b2b_in_ready_%0d got=%b want=%b", c, in_ready, c[0]); end
      if (c[0]) begin
        if (c < 5) in_inst = insts[(c + 1) / 2];
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd3;
    total++; if (busy !== 1'b0 || inst_count !== exp_cnt)
      begin bad++; $display("FAIL b2b_done got=%b/%0d want=0/%0d", busy, inst_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    in_inst = inst_a; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_last !== 1'b1 || out_dword !== 32'hFA000040)
      begin bad++; $display("FAIL mid_held_dw1 got=%b/%h want=1/FA000040", out_last, out_dword); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_dword !== 32'h0 || inst_count !== 16'd0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL mid_reset got=%b/%h/%0d/%b want=0/00000000/0/1", out_valid, out_dword, inst_count, in_ready); end
    reset = 1'b1; out_ready = 1'b1;
    exp_cnt = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || out_dword !== 32'h0 || busy !== 1'b0)
        begin bad++; $display("FAIL mid_stale_%0d got=%b/%h/%b want=0/00000000/0", i, out_valid, out_dword, busy); end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] wrap_exp [5];
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 16'd0;
    for (int k = 0; k < 5; k++) begin
      in_inst = inst_ones; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid2 !== 1'b1 || out_last2 !== 1'b1 || busy2 !== 1'b1 || in_ready2 !== 1'b1 || out_dword2 !== 32'hFE1FFFFF)
        begin bad++; $display("FAIL wrap_dw1_%0d got=%b%b%b%b/%h want=1111/FE1FFFFF", k, out_valid2, out_last2, busy2, in_ready2, out_dword2); end
      @(negedge clk);
      exp_cnt = exp_cnt + 16'd1;
      total++; if (inst_count2 !== wrap_exp[k])
        begin bad++; $display("FAIL wrap_count_%0d got=%0d want=%0d", k, inst_count2, wrap_exp[k]); end
      total++; if (inst_count !== exp_cnt)
        begin bad++; $display("FAIL wrap_count16_%0d got=%0d want=%0d", k, inst_count, exp_cnt); end
    end
  endtask

  initial begin
    inst_a    = {6'h04, 7'h10, 1'b0, 1'b1, 8'h02, 21'h000040, 7'h7D};
    inst_ones = {6'h3F, 7'h7F, 1'b1, 1'b1, 8'hFF, 21'h1FFFFF, 7'h7F};
    inst_c    = {6'h00, 7'h00, 1'b1, 1'b0, 8'h5A, 21'h012345, 7'h01};
    inst_junk = {6'h15, 7'h2A, 1'b1, 1'b0, 8'hC3, 21'h0ABCDE, 7'h33};
    test_reset();
    test_single("single", inst_a, 32'hF4090404, 32'hFA000040);
    test_single("ones", inst_ones, 32'hF7FD5FFF, 32'hFE1FFFFF);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
